// File: rtl/read_capture_pkg.sv
// Shared state encoding and word-width helpers for the DFI read capture aligner.
package read_capture_pkg;

  typedef logic [0:0] rdcap_state_t;

  localparam rdcap_state_t S_EVEN = 1'b0;
  localparam rdcap_state_t S_HALF = 1'b1;

  function automatic int unsigned rdcap_word_w(input int unsigned dq_width,
                                               input int unsigned nbeats);
    return dq_width * nbeats;
  endfunction

  function automatic int unsigned rdcap_half_w(input int unsigned dq_width,
                                               input int unsigned nbeats);
    return (dq_width * nbeats) / 2;
  endfunction

endpackage

// File: rtl/rdcap_skid_fifo.sv
// Synchronous skid FIFO; a push while full is accepted only if a pop frees the slot that cycle.
module rdcap_skid_fifo #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  always_comb begin
    count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/read_capture_aligner.sv
// DFI read capture: registers read words, realigns odd-phase bursts, buffers in a skid FIFO.
// Optional saturating traffic counters are built when RDCAP_STATS_EN is defined.
module read_capture_aligner
  import read_capture_pkg::*;
#(
  parameter int unsigned DQ_WIDTH    = 64,
  parameter int unsigned NBEATS      = 4,
  parameter int unsigned SKID_DEPTH  = 8,
  parameter int unsigned SKID_MARGIN = 3,
  localparam int unsigned W = rdcap_word_w(DQ_WIDTH, NBEATS),
  localparam int unsigned H = rdcap_half_w(DQ_WIDTH, NBEATS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] dfi_rddata,
  input  logic         dfi_rddata_valid,
  input  logic         dfi_rddata_valid_odd,
  output logic         dfi_clk_disable,
  input  logic         rdback_fifo_almost_full,
  input  logic         rdback_fifo_full,
  output logic         rdback_fifo_wren,
  output logic [W-1:0] rdback_fifo_wrdata,
  output logic         align_err,
  output logic         skid_overflow,
`ifdef RDCAP_STATS_EN
  output logic [31:0]  stat_words,
  output logic [15:0]  stat_drops,
`endif
  input  logic         err_clr
);

  localparam int unsigned CW = $clog2(SKID_DEPTH) + 1;
  localparam int unsigned IW = $clog2(2 * NBEATS + 1);

  logic [W-1:0]  d_q;
  logic          v_q, vo_q;
  rdcap_state_t  state_q, state_d;
  logic [H-1:0]  stash_q, stash_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          push;
  logic [W-1:0]  push_data;
  logic          set_align;

  logic [W-1:0]  skid_rdata;
  logic          skid_full, skid_empty, skid_pop, skid_drop;
  logic [CW-1:0] skid_count;
  logic [CW-1:0] free_entries;

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          clk_dis_q, align_err_q, overflow_q;

  always_comb begin
    state_d   = state_q;
    stash_d   = stash_q;
    idle_d    = idle_q;
    push      = 1'b0;
    push_data = d_q;
    set_align = 1'b0;
    case (state_q)
      S_EVEN: begin
        if (v_q) begin
          if (vo_q) begin
            stash_d = d_q[W-1:H];
            idle_d  = '0;
            state_d = S_HALF;
          end else begin
            push = 1'b1;
          end
        end
      end
      S_HALF: begin
        if (v_q) begin
          push      = 1'b1;
          push_data = {d_q[H-1:0], stash_q};
          idle_d    = '0;
          if (vo_q) stash_d = d_q[W-1:H];
          else      state_d = S_EVEN;
        end else if (idle_q == IW'(NBEATS)) begin
          // Burst tail never came: the stash is stale and is discarded.
          set_align = 1'b1;
          stash_d   = '0;
          idle_d    = '0;
          state_d   = S_EVEN;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
      default: state_d = S_EVEN;
    endcase
  end

  assign skid_pop     = ~skid_empty & ~rdback_fifo_full;
  assign skid_drop    = push & skid_full & ~skid_pop;
  assign free_entries = CW'(SKID_DEPTH) - skid_count;

  rdcap_skid_fifo #(
    .WIDTH (W),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_data),
    .pop   (skid_pop),
    .rdata (skid_rdata),
    .full  (skid_full),
    .empty (skid_empty),
    .count (skid_count)
  );

  // Output word is held if the readback FIFO fills before it is taken.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (skid_pop) begin
      out_valid_d = 1'b1;
      out_data_d  = skid_rdata;
    end else if (!rdback_fifo_full) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q         <= '0;
      v_q         <= 1'b0;
      vo_q        <= 1'b0;
      state_q     <= S_EVEN;
      stash_q     <= '0;
      idle_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      clk_dis_q   <= 1'b0;
      align_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      d_q         <= dfi_rddata;
      v_q         <= dfi_rddata_valid;
      vo_q        <= dfi_rddata_valid_odd;
      state_q     <= state_d;
      stash_q     <= stash_d;
      idle_q      <= idle_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      clk_dis_q   <= rdback_fifo_almost_full | rdback_fifo_full |
                     (free_entries <= CW'(SKID_MARGIN));
      align_err_q <= set_align ? 1'b1 : (err_clr ? 1'b0 : align_err_q);
      overflow_q  <= skid_drop ? 1'b1 : (err_clr ? 1'b0 : overflow_q);
    end
  end

  assign rdback_fifo_wren   = out_valid_q & ~rdback_fifo_full;
  assign rdback_fifo_wrdata = out_data_q;
  assign dfi_clk_disable    = clk_dis_q;
  assign align_err          = align_err_q;
  assign skid_overflow      = overflow_q;

`ifdef RDCAP_STATS_EN
  logic [31:0] stat_words_q;
  logic [15:0] stat_drops_q;

  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      stat_words_q <= '0;
      stat_drops_q <= '0;
    end else begin
      if (rdback_fifo_wren && (stat_words_q != '1)) stat_words_q <= stat_words_q + 32'd1;
      if (skid_drop && (stat_drops_q != '1))        stat_drops_q <= stat_drops_q + 16'd1;
    end
  end

  assign stat_words = stat_words_q;
  assign stat_drops = stat_drops_q;
`endif

endmodule
